rr_grant_data_mux: RTL and testbench

- Downstream stage of the 4-requester round-robin fixed-time arbiter. Consumes its one-hot `gnt` and moves payload beats from the granted requester onto one shared output channel.
- Per-requester valid/ready inputs; single registered valid/ready output tagged with the source index.
- Caps beats per grant tenure and flags malformed grants.

---
 rtl/rr_arb_pkg.sv | 17 +
 rtl/rr_onehot_enc.sv | 22 ++
 rtl/rr_grant_data_mux.sv | 145 ++++++++++++++
 tb/tb_rr_grant_data_mux.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/rr_arb_pkg.sv
// Shared definitions for the round-robin arbiter slice: default sizes, FSM state
// encodings and the one-hot grant check.
package rr_arb_pkg;

  localparam int unsigned NumReqDef = 4;
  localparam int unsigned SrcWDef   = $clog2(NumReqDef);

  localparam logic [1:0] StIdle      = 2'd0;
  localparam logic [1:0] StActive    = 2'd1;
  localparam logic [1:0] StExhausted = 2'd2;

  // True when exactly one bit of v is set.
  function automatic logic onehot_check(input logic [31:0] v);
    return (v != '0) && ((v & (v - 32'd1)) == '0);
  endfunction

endpackage

// File: rtl/rr_onehot_enc.sv
// Encodes a one-hot grant vector into a requester index and flags whether the
// vector really is one-hot.
module rr_onehot_enc
  import rr_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = NumReqDef,
  parameter int unsigned SRC_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] gnt_i,
  output logic [SRC_W-1:0]   idx_o,
  output logic               onehot_o
);

  always_comb begin
    idx_o = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt_i[i]) idx_o = SRC_W'(i);
    end
    onehot_o = onehot_check(32'(gnt_i));
  end

endmodule

// File: rtl/rr_grant_data_mux.sv
// Moves payload beats from the granted requester onto one registered output channel.
// Define RR_MUX_BEAT_LIMIT_EN to cap beats per grant tenure at MAX_BEATS.
module rr_grant_data_mux
  import rr_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = NumReqDef,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MAX_BEATS = 4,
  parameter int unsigned SRC_W     = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        gnt,
  input  logic [NUM_REQ-1:0]        in_valid,
  input  logic [NUM_REQ*DATA_W-1:0] in_data,
  output logic [NUM_REQ-1:0]        in_ready,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  output logic [SRC_W-1:0]          out_src,
  input  logic                      out_ready,
  output logic                      grant_err
);

  localparam int unsigned CntW = $clog2(MAX_BEATS + 1);

  logic [1:0]         state_q, state_d;
  logic [NUM_REQ-1:0] cur_gnt_q, cur_gnt_d;
  logic [CntW-1:0]    beat_cnt_q, beat_cnt_d;
  logic               out_valid_q, out_valid_d;
  logic [DATA_W-1:0]  out_data_q, out_data_d;
  logic [SRC_W-1:0]   out_src_q, out_src_d;

  logic [SRC_W-1:0]   idx;
  logic               onehot;
  logic               slot_free, same_gnt, cnt_ok, accept;
  logic [CntW-1:0]    cnt_inc;

  rr_onehot_enc #(
    .NUM_REQ (NUM_REQ),
    .SRC_W   (SRC_W)
  ) u_enc (
    .gnt_i    (gnt),
    .idx_o    (idx),
    .onehot_o (onehot)
  );

  always_comb begin
    slot_free = !out_valid_q || out_ready;
    same_gnt  = (gnt == cur_gnt_q);
`ifdef RR_MUX_BEAT_LIMIT_EN
    cnt_ok    = (beat_cnt_q < CntW'(MAX_BEATS));
`else
    cnt_ok    = 1'b1;
`endif
    // cur_gnt_q is one-hot in StActive, so same_gnt also implies a legal grant.
    in_ready  = (state_q == StActive && slot_free && same_gnt && cnt_ok) ? cur_gnt_q : '0;
    accept    = |(in_ready & in_valid);
    grant_err = (gnt != '0) && !onehot;
    cnt_inc   = (beat_cnt_q == '1) ? beat_cnt_q : beat_cnt_q + CntW'(1);
  end

  always_comb begin
    state_d    = state_q;
    cur_gnt_d  = cur_gnt_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      StIdle: begin
        if (onehot) begin
          state_d    = StActive;
          cur_gnt_d  = gnt;
          beat_cnt_d = '0;
        end
      end
      StActive: begin
        if (!onehot) begin
          state_d   = StIdle;
          cur_gnt_d = '0;
        end else if (!same_gnt) begin
          cur_gnt_d  = gnt;
          beat_cnt_d = '0;
        end else if (accept) begin
          beat_cnt_d = cnt_inc;
`ifdef RR_MUX_BEAT_LIMIT_EN
          if (cnt_inc == CntW'(MAX_BEATS)) state_d = StExhausted;
`endif
        end
      end
`ifdef RR_MUX_BEAT_LIMIT_EN
      StExhausted: begin
        if (!same_gnt) begin
          if (onehot) begin
            state_d    = StActive;
            cur_gnt_d  = gnt;
            beat_cnt_d = '0;
          end else begin
            state_d   = StIdle;
            cur_gnt_d = '0;
          end
        end
      end
`endif
      default: begin
        state_d   = StIdle;
        cur_gnt_d = '0;
      end
    endcase
  end

  // Single-entry output slot: load on accept, otherwise drain on out_ready.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data[idx*DATA_W +: DATA_W];
      out_src_d   = idx;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cur_gnt_q   <= '0;
      beat_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
    end else begin
      state_q     <= state_d;
      cur_gnt_q   <= cur_gnt_d;
      beat_cnt_q  <= beat_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

endmodule

// File: tb/tb_rr_grant_data_mux.sv
// Directed bench for rr_grant_data_mux: cycle table, rotating-grant scoreboard
// and asynchronous reset check. Expectations follow RR_MUX_BEAT_LIMIT_EN.
module tb_rr_grant_data_mux;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  gnt;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_src;
  logic        out_ready;
  logic        grant_err;

  int checks = 0;
  int errors = 0;

  rr_grant_data_mux #(
    .NUM_REQ   (4),
    .DATA_W    (8),
    .MAX_BEATS (4),
    .SRC_W     (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .gnt       (gnt),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready),
    .grant_err (grant_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] gnt;
    logic [3:0] iv;
    logic       ordy;
    logic [3:0] rdy;
    logic       ov;
    logic [7:0] od;
    logic [1:0] os;
    logic       err;
  } vec_t;

  vec_t tbl[28];

  function automatic vec_t mk(logic [3:0] g, logic [3:0] iv, logic ordy, logic [3:0] rdy,
                              logic ov, logic [7:0] od, logic [1:0] os, logic err);
    vec_t v;
    v.gnt = g; v.iv = iv; v.ordy = ordy; v.rdy = rdy;
    v.ov = ov; v.od = od; v.os = os; v.err = err;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
    end
  endtask

  logic [9:0] exp_q[$];
  logic [9:0] e;
  int         seen;

  initial begin
    // Requester bytes: 0=A5 1=B1 2=C2 3=D3
    tbl[0]  = mk(4'h1, 4'h1, 1, 4'h0, 0, 8'h00, 2'd0, 0);
    tbl[1]  = mk(4'h1, 4'h1, 1, 4'h1, 0, 8'h00, 2'd0, 0);
    tbl[2]  = mk(4'h0, 4'h0, 1, 4'h0, 1, 8'hA5, 2'd0, 0);
    tbl[3]  = mk(4'h0, 4'h0, 1, 4'h0, 0, 8'h00, 2'd0, 0);
    tbl[4]  = mk(4'h4, 4'h4, 1, 4'h0, 0, 8'h00, 2'd0, 0);
    tbl[5]  = mk(4'h4, 4'h4, 1, 4'h4, 0, 8'h00, 2'd0, 0);
    tbl[6]  = mk(4'h4, 4'h4, 1, 4'h4, 1, 8'hC2, 2'd2, 0);
    tbl[7]  = mk(4'h4, 4'h4, 1, 4'h4, 1, 8'hC2, 2'd2, 0);
    tbl[8]  = mk(4'h4, 4'h4, 1, 4'h4, 1, 8'hC2, 2'd2, 0);
`ifdef RR_MUX_BEAT_LIMIT_EN
    tbl[9]  = mk(4'h4, 4'h4, 1, 4'h0, 1, 8'hC2, 2'd2, 0);
    tbl[10] = mk(4'h8, 4'h8, 1, 4'h0, 0, 8'h00, 2'd0, 0);
`else
    tbl[9]  = mk(4'h4, 4'h4, 1, 4'h4, 1, 8'hC2, 2'd2, 0);
    tbl[10] = mk(4'h8, 4'h8, 1, 4'h0, 1, 8'hC2, 2'd2, 0);
`endif
    tbl[11] = mk(4'h8, 4'h8, 1, 4'h8, 0, 8'h00, 2'd0, 0);
    tbl[12] = mk(4'h0, 4'h0, 1, 4'h0, 1, 8'hD3, 2'd3, 0);
    tbl[13] = mk(4'h2, 4'h2, 1, 4'h0, 0, 8'h00, 2'd0, 0);
    tbl[14] = mk(4'h2, 4'h2, 1, 4'h2, 0, 8'h00, 2'd0, 0);
    tbl[15] = mk(4'h8, 4'hA, 0, 4'h0, 1, 8'hB1, 2'd1, 0);
    tbl[16] = mk(4'h8, 4'h8, 0, 4'h0, 1, 8'hB1, 2'd1, 0);
    tbl[17] = mk(4'h8, 4'h8, 0, 4'h0, 1, 8'hB1, 2'd1, 0);
    tbl[18] = mk(4'h8, 4'h8, 1, 4'h8, 1, 8'hB1, 2'd1, 0);
    tbl[19] = mk(4'h0, 4'h0, 1, 4'h0, 1, 8'hD3, 2'd3, 0);
    tbl[20] = mk(4'h6, 4'h6, 1, 4'h0, 0, 8'h00, 2'd0, 1);
    tbl[21] = mk(4'h0, 4'h0, 1, 4'h0, 0, 8'h00, 2'd0, 0);
    tbl[22] = mk(4'h1, 4'h1, 1, 4'h0, 0, 8'h00, 2'd0, 0);
    tbl[23] = mk(4'h1, 4'h1, 1, 4'h1, 0, 8'h00, 2'd0, 0);
    tbl[24] = mk(4'h3, 4'h1, 0, 4'h0, 1, 8'hA5, 2'd0, 1);
    tbl[25] = mk(4'h0, 4'h0, 0, 4'h0, 1, 8'hA5, 2'd0, 0);
    tbl[26] = mk(4'h0, 4'h0, 1, 4'h0, 1, 8'hA5, 2'd0, 0);
    tbl[27] = mk(4'h0, 4'h0, 1, 4'h0, 0, 8'h00, 2'd0, 0);

    rst_n = 1'b0; gnt = '0; in_valid = '0; in_data = 32'hD3C2_B1A5; out_ready = 1'b1;
    @(negedge clk);
    check("reset.out_valid", 32'(out_valid), 0);
    check("reset.out_data", 32'(out_data), 0);
    check("reset.out_src", 32'(out_src), 0);
    check("reset.in_ready", 32'(in_ready), 0);
    check("reset.grant_err", 32'(grant_err), 0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 28; i++) begin
      gnt = tbl[i].gnt; in_valid = tbl[i].iv; out_ready = tbl[i].ordy;
      @(negedge clk);
      check($sformatf("vec%0d.in_ready", i), 32'(in_ready), 32'(tbl[i].rdy));
      check($sformatf("vec%0d.grant_err", i), 32'(grant_err), 32'(tbl[i].err));
      check($sformatf("vec%0d.out_valid", i), 32'(out_valid), 32'(tbl[i].ov));
      if (tbl[i].ov) begin
        check($sformatf("vec%0d.out_data", i), 32'(out_data), 32'(tbl[i].od));
        check($sformatf("vec%0d.out_src", i), 32'(out_src), 32'(tbl[i].os));
      end
      @(posedge clk); #1;
    end

    // Rotating grant, 3 cycles per tenure: first cycle is a grant change, then 2 beats.
    in_data = 32'h4433_2211;
    for (int s = 0; s < 4; s++) begin
      exp_q.push_back({2'(s), 8'(8'h11 * (s + 1))});
      exp_q.push_back({2'(s), 8'(8'h11 * (s + 1))});
    end
    seen = 0;
    for (int c = 0; c < 16; c++) begin
      gnt = (c < 12) ? 4'(4'h1 << (c / 3)) : 4'h0;
      in_valid = 4'hF; out_ready = 1'b1;
      @(negedge clk);
      check($sformatf("rot%0d.in_ready", c), 32'(in_ready),
            32'((c < 12 && (c % 3) != 0) ? gnt : 4'h0));
      if (out_valid) begin
        seen++;
        if (exp_q.size() == 0) begin
          check($sformatf("rot%0d.extra_beat", c), 32'(out_src), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("rot%0d.out_src", c), 32'(out_src), 32'(e[9:8]));
          check($sformatf("rot%0d.out_data", c), 32'(out_data), 32'(e[7:0]));
        end
      end
      @(posedge clk); #1;
    end
    check("rot.beat_count", 32'(seen), 8);

    // Asynchronous reset with a beat pending.
    gnt = 4'h1; in_valid = 4'h1; out_ready = 1'b0; in_data = 32'hD3C2_B1A5;
    repeat (2) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("arst.pending_valid", 32'(out_valid), 1);
    #1 rst_n = 1'b0;
    #1;
    check("arst.out_valid", 32'(out_valid), 0);
    check("arst.in_ready", 32'(in_ready), 0);
    check("arst.out_data", 32'(out_data), 0);
    @(negedge clk);
    gnt = 4'h0; in_valid = 4'h0; out_ready = 1'b1;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("arst.after_valid", 32'(out_valid), 0);
    check("arst.after_ready", 32'(in_ready), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
